// File: rtl/screen_line_fetch_if.sv
// Frame-buffer read port: screen_line_fetch drives requests (master), memory returns data (slave).
interface screen_line_fetch_if #(
  parameter int unsigned DW     = 16,
  parameter int unsigned MEM_AW = 15
);
  logic              mem_ce;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_vld;
  logic [DW-1:0]     mem_dat;

  modport master (output mem_ce, output mem_addr, input mem_vld, input mem_dat);
  modport slave  (input mem_ce, input mem_addr, output mem_vld, output mem_dat);
endinterface

// File: rtl/screen_line_fetch.sv
// Per-line frame-buffer fetch into a ping-pong line buffer, serving 1bpp pixels as DAC levels.
// Optional macro SCREEN_FETCH_TIMEOUT_EN: per-word mem_vld timeout in WAIT/DRAIN.
module screen_line_fetch #(
  parameter int unsigned       DW            = 16,
  parameter int unsigned       MEM_AW        = 15,
  parameter logic [MEM_AW-1:0] BASE_ADDR     = 15'h4000,
  parameter int unsigned       PIX_ROWS      = 256,
  parameter int unsigned       WORDS_PER_ROW = 32,
  parameter logic [7:0]        PIX_SET       = 8'h4C,
  parameter logic [7:0]        PIX_CLR       = 8'hFF
`ifdef SCREEN_FETCH_TIMEOUT_EN
  , parameter int unsigned     TIMEOUT       = 63
`endif
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                hsync,
  input  logic                vsync,
  input  logic [9:0]          pf_pix_row,
  input  logic [9:0]          pf_pix_col,
  output logic [7:0]          pix_val,
  screen_line_fetch_if.master mem,
  output logic                fetch_busy,
  output logic                underrun
);
  localparam int unsigned CW  = 10;
  localparam int unsigned WIW = $clog2(WORDS_PER_ROW);
  localparam int unsigned BIW = $clog2(DW);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} state_t;

  state_t           state;
  logic             hs_r, hs_p, vs_r, vs_p;
  logic             front;
  logic [1:0]       bank_vld, bank_blank;
  logic [9:0]       row;
  logic [WIW-1:0]   word;
  logic             start_pend;
  logic [DW-1:0]    line_buf [2][WORDS_PER_ROW];

  logic             hs_edge_c, vs_edge_c, abort_c, back_c, row_ok_c;
  logic             tmo_c, take_c, drained_c, free_c, last_c, col_ok_c;
  logic [DW-1:0]    wr_dat_c;
  logic [CW-BIW-1:0] col_word_c;
  logic [BIW-1:0]   col_bit_c;

  function automatic logic [MEM_AW-1:0] word_addr(input logic [9:0] r, input logic [WIW-1:0] w);
    return MEM_AW'(32'(BASE_ADDR) + 32'(r) * WORDS_PER_ROW + 32'(w));
  endfunction

  assign hs_edge_c  = hs_r & ~hs_p;
  assign vs_edge_c  = vs_r & ~vs_p;
  assign abort_c    = hs_edge_c | vs_edge_c;
  assign back_c     = ~front;
  assign row_ok_c   = 32'(pf_pix_row) < PIX_ROWS;
  assign last_c     = 32'(word) == WORDS_PER_ROW - 1;
  assign take_c     = (state == ST_WAIT) && (mem.mem_vld || tmo_c);
  // outstanding request resolved this cycle (data, drain pulse or timeout)
  assign drained_c  = ((state == ST_WAIT) || (state == ST_DRAIN)) && (mem.mem_vld || tmo_c);
  assign free_c     = (state == ST_IDLE) || drained_c;
  assign col_word_c = pf_pix_col[CW-1:BIW];
  assign col_bit_c  = pf_pix_col[BIW-1:0];
  assign col_ok_c   = 32'(col_word_c) < WORDS_PER_ROW;

`ifdef SCREEN_FETCH_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0] to_cnt;

  // cycles spent waiting on the current request; saturates
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if ((state == ST_WAIT) || (state == ST_DRAIN)) begin
      if (32'(to_cnt) < TIMEOUT) to_cnt <= to_cnt + TOW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign tmo_c    = ((state == ST_WAIT) || (state == ST_DRAIN)) && (32'(to_cnt) >= TIMEOUT - 1);
  assign wr_dat_c = mem.mem_vld ? mem.mem_dat : '0;
`else
  assign tmo_c    = 1'b0;
  assign wr_dat_c = mem.mem_dat;
`endif

  always_ff @(posedge clk) begin
    if (take_c && !abort_c) line_buf[back_c][word] <= wr_dat_c;
  end

  // sync edge detect, bank swap and fetch FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_r <= 1'b0; hs_p <= 1'b0; vs_r <= 1'b0; vs_p <= 1'b0;
      state <= ST_IDLE; front <= 1'b0; bank_vld <= '0; bank_blank <= '0;
      row <= '0; word <= '0; start_pend <= 1'b0;
      mem.mem_ce <= 1'b0; mem.mem_addr <= '0; fetch_busy <= 1'b0; underrun <= 1'b0;
    end else begin
      hs_r <= hsync; hs_p <= hs_r;
      vs_r <= vsync; vs_p <= vs_r;
      mem.mem_ce <= 1'b0;
      if (vs_edge_c) begin
        bank_vld   <= '0;
        bank_blank <= '0;
        start_pend <= 1'b0;
        state      <= free_c ? ST_IDLE : ST_DRAIN;
        fetch_busy <= ~free_c;
      end else if (hs_edge_c) begin
        front <= ~front;
        if (state != ST_IDLE) underrun <= 1'b1;
        row  <= pf_pix_row;
        word <= '0;
        bank_vld[front]   <= ~row_ok_c;
        bank_blank[front] <= ~row_ok_c;
        if (free_c && row_ok_c) begin
          state <= ST_REQ; fetch_busy <= 1'b1; start_pend <= 1'b0;
          mem.mem_ce <= 1'b1; mem.mem_addr <= word_addr(pf_pix_row, '0);
        end else if (free_c) begin
          state <= ST_IDLE; fetch_busy <= 1'b0; start_pend <= 1'b0;
        end else begin
          state <= ST_DRAIN; fetch_busy <= 1'b1; start_pend <= row_ok_c;
        end
      end else begin
        case (state)
          ST_REQ: state <= ST_WAIT;
          ST_WAIT: begin
            if (take_c) begin
              if (last_c) begin
                bank_vld[back_c] <= 1'b1;
                state <= ST_IDLE; fetch_busy <= 1'b0;
              end else begin
                word <= word + WIW'(1);
                state <= ST_REQ;
                mem.mem_ce <= 1'b1; mem.mem_addr <= word_addr(row, word + WIW'(1));
              end
            end
          end
          ST_DRAIN: begin
            if (drained_c) begin
              if (start_pend) begin
                state <= ST_REQ; start_pend <= 1'b0;
                mem.mem_ce <= 1'b1; mem.mem_addr <= word_addr(row, '0);
              end else begin
                state <= ST_IDLE; fetch_busy <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // pixel lookup from the front bank; bit 0 is the leftmost pixel of a word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_val <= PIX_CLR;
    end else begin
      pix_val <= (bank_vld[front] && !bank_blank[front] && col_ok_c &&
                  line_buf[front][col_word_c[WIW-1:0]][col_bit_c]) ? PIX_SET : PIX_CLR;
    end
  end
endmodule

// File: doc/screen_line_fetch.md
Name: screen_line_fetch

Overview:
- Upstream pixel-source stage for the NTSC scan unit.
- Owns the external memory port: on each line start it fetches one screen row of 16-bit words from the memory-mapped frame buffer into a ping-pong line buffer.
- Serves 1-bit-per-pixel data as 8-bit DAC levels to the scan unit, using its prefetch row/column coordinates.
- Replaces the tied-off memory interface in the screen top level.

Parameters:
DW, 16, memory word width; pixels per word
MEM_AW, 15, memory address width
BASE_ADDR, 15'h4000, word address of row 0 word 0
PIX_ROWS, 256, displayable rows; rows >= PIX_ROWS are blank
WORDS_PER_ROW, 32, words per row (512 pixels)
PIX_SET, 8'h4C, DAC level for pixel bit = 1 (black)
PIX_CLR, 8'hFF, DAC level for pixel bit = 0 and for blank (white)
TIMEOUT, 63, mem_vld wait limit in cycles (optional feature only)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
hsync  in  1  line sync from scan unit; rising edge = line start
vsync  in  1  frame sync from scan unit; rising edge = frame start
pf_pix_row  in  10  prefetch row; sampled at hsync rising edge
pf_pix_col  in  10  column whose pixel is wanted next cycle
pix_val  out  8  registered pixel DAC level
mem_ce  out  1  one-cycle read request strobe
mem_addr  out  MEM_AW  word address; valid while mem_ce = 1
mem_vld  in  1  read data valid; one pulse per request, latency >= 1, unbounded
mem_dat  in  DW  read data; valid while mem_vld = 1
fetch_busy  out  1  fetch FSM not IDLE
underrun  out  1  sticky; set when a line swap occurs before its fetch completed

Behaviour:
- Decided: one clock, clk; reset rstn is asynchronous, active-low.
- Reset values: pix_val = PIX_CLR; mem_ce = 0; mem_addr = 0; fetch_busy = 0; underrun = 0. Both buffers are invalid, FSM is IDLE, and the bank pointer is 0.
- Sync edges: hsync and vsync are registered once; an edge is detected as current & ~previous.
- Buffers: two banks, each WORDS_PER_ROW x DW, with a valid flag per bank.
  - Front bank feeds output. Back bank is the fetch target.
- hsync edge:
  - Swap banks. New front = old back. If the old back was not valid, or its fetch was in progress, the new front is invalid; an in-progress fetch additionally sets underrun.
  - Capture row = pf_pix_row.
  - Abort any fetch in progress (same drain rule as vsync).
  - If row < PIX_ROWS, start a fetch into the new back bank. Otherwise mark the new back bank valid-blank: all pixels read as PIX_CLR and no memory access is made.
  - Consequence: the row captured at hsync edge N is displayed during line N+1.
- vsync edge: invalidate both banks and abort any fetch. No new fetch starts until the next hsync edge. If vsync and hsync edges occur in the same cycle, vsync wins and the hsync edge is ignored.
- Fetch FSM:
  - IDLE -> REQ on fetch start; word index w = 0.
  - REQ: mem_ce = 1 for exactly one cycle, mem_addr = (BASE_ADDR + row*WORDS_PER_ROW + w) mod 2^MEM_AW. Next state is WAIT.
  - WAIT: on mem_vld, write mem_dat to back[w].
    - If w = WORDS_PER_ROW-1: set back valid, go to IDLE.
    - Otherwise: w++, go to REQ.
  - WAIT, abort: go to DRAIN.
  - DRAIN: discard the next mem_vld, then go to IDLE. If a new fetch start is pending, go to REQ after the drain instead.
  - Abort while in REQ: the request is already issued, so go to DRAIN.
  - Only one request is outstanding at any time. mem_vld in IDLE or REQ is ignored.
- Pixel path (1 cycle latency):
  - Word index = pf_pix_col / DW; bit index = pf_pix_col % DW, with bit 0 the leftmost pixel.
  - pix_val <= PIX_SET if the front bank is valid, not blank, the word index < WORDS_PER_ROW, and the selected bit = 1. Otherwise pix_val <= PIX_CLR.
  - Columns >= WORDS_PER_ROW*DW produce PIX_CLR.
- underrun: sticky once set; cleared only by reset.

Optional Feature:
- Macro: SCREEN_FETCH_TIMEOUT_EN.
- Defined: a WAIT-state counter. If mem_vld has not arrived after TIMEOUT cycles in WAIT, write 0 to back[w] and advance as if data had arrived. A late mem_vld that arrives while in IDLE or REQ is ignored. In DRAIN, the timeout also exits to IDLE.
- Not defined: WAIT and DRAIN wait indefinitely; there is no counter logic.

Test Plan:
- Row fetch: hsync edge with pf_pix_row = 3, memory returns mem_vld 2 cycles after each mem_ce -> 32 requests at addresses 0x4060..0x407F. At the next hsync edge, with word0 = 16'h0001: col 0 -> pix_val 8'h4C, col 1 -> 8'hFF.
- Blank row: pf_pix_row = 300 at hsync edge -> no mem_ce. The following line shows all columns as 8'hFF; fetch_busy stays 0.
- Underrun: memory latency 20 cycles, hsync period 200 cycles -> fetch incomplete at the next edge; underrun = 1, whole line 8'hFF, and a new fetch starts for the new row.
- vsync mid-fetch: vsync edge while in WAIT -> next mem_vld is discarded, no mem_ce until the next hsync, and pix_val = 8'hFF for the line.
- Simultaneous hsync and vsync edges -> treated as vsync only: no swap and no fetch start.
- Reset mid-fetch: rstn low in WAIT -> mem_ce = 0, fetch_busy = 0, pix_val = 8'hFF immediately. With SCREEN_FETCH_TIMEOUT_EN and a memory that never returns mem_vld, each word completes after 63 cycles and the row reads as all 8'hFF.
